// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM state encoding and default width for the arithmetic datapath
package arith_pkg;
  localparam int N_DEF = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/count_div_step.sv
// count_div_step: one restoring iteration, shift left then trial-subtract the divisor
module count_div_step
  import arith_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [2*N:0] acc,
  input  logic [N-1:0] dv,
  output logic [2*N:0] nxt
);
  logic [N+1:0] t;
  // the shifted-out MSB joins the trial subtraction so no carry is dropped
  assign t = acc[2*N:N-1] - {2'b0, dv};
  assign nxt = t[N+1] ? {acc[2*N-1:0], 1'b0} : {t[N:0], acc[N-2:0], 1'b1};
endmodule

// File: rtl/count_div.sv
// count_div: sequential restoring divider, 2N/N bits, st/done handshake; COUNT_DIV_SIGNED_EN enables two's complement operands
module count_div
  import arith_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           st,
  input  logic [2*N-1:0] a,
  input  logic [N-1:0]   b,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           ovf,
  output logic           done,
  output logic           busy
);
  localparam int CW = $clog2(N);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [2*N:0] acc, acc_nx;
  logic [N-1:0] dv;
  logic [2*N-1:0] ua;
  logic [N-1:0] ub, qo, ro;
  logic early, last, oo;
`ifdef COUNT_DIV_SIGNED_EN
  localparam logic [N-1:0] LIM = {1'b1, {(N-1){1'b0}}};
  logic sq, sr;
  logic [N-1:0] qm, rm;
  logic big;
  assign ua = a[2*N-1] ? -a : a;
  assign ub = b[N-1] ? -b : b;
  assign qm = acc_nx[N-1:0];
  assign rm = acc_nx[2*N-1:N];
  assign big = sq ? (qm > LIM) : (qm >= LIM);
  assign qo = big ? '1 : (sq ? -qm : qm);
  assign ro = big ? '0 : (sr ? -rm : rm);
  assign oo = big;
  // operand signs captured at accept, applied on the final write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sq <= 1'b0;
      sr <= 1'b0;
    end else if (state == IDLE && st) begin
      sq <= a[2*N-1] ^ b[N-1];
      sr <= a[2*N-1];
    end
`else
  assign ua = a;
  assign ub = b;
  assign qo = acc_nx[N-1:0];
  assign ro = acc_nx[2*N-1:N];
  assign oo = 1'b0;
`endif
  assign early = (ub == '0) || (ua[2*N-1:N] >= ub);
  assign last = (cnt == CW'(N-1));
  assign done = (state == DONE);
  assign busy = (state != IDLE);
  count_div_step #(.N(N)) u_step (
    .acc(acc),
    .dv (dv),
    .nxt(acc_nx)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next state: overflow skips straight to DONE, DONE always returns to IDLE
  always_comb begin
    nxt = (state == IDLE) ? (st ? (early ? DONE : CALC) : IDLE) :
          (state == CALC) ? (last ? DONE : CALC) : IDLE;
  end
  // datapath: capture on accept, one quotient bit per CALC edge, results written on DONE entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      dv        <= '0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (st) begin
            if (early) begin
              quotient  <= '1;
              remainder <= '0;
              ovf       <= 1'b1;
            end else begin
              acc <= {1'b0, ua};
              dv  <= ub;
              cnt <= '0;
            end
          end
        CALC: begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (last) begin
            quotient  <= qo;
            remainder <= ro;
            ovf       <= oo;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_count_div.sv
// tb_count_div: randomized and directed checks of count_div against an arithmetic reference model
module tb_count_div;
  localparam int N = 8;
  logic clk = 1'b0, rst_n = 1'b0, st = 1'b0;
  logic [2*N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [N-1:0] quotient, remainder;
  logic ovf, done, busy;
  logic [N-1:0] pq = '0, pr = '0;
  logic po = 1'b0;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  count_div #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .st(st), .a(a), .b(b),
    .quotient(quotient), .remainder(remainder), .ovf(ovf), .done(done), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [2*N-1:0] x, input logic [N-1:0] y,
                       output logic [N-1:0] q, output logic [N-1:0] r, output logic o, output int lat);
`ifdef COUNT_DIV_SIGNED_EN
    int sx, sy, mq;
    bit neg;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sy == 0) begin
      o = 1'b1; q = '1; r = '0; lat = 1;
    end else begin
      mq = (sx < 0 ? -sx : sx) / (sy < 0 ? -sy : sy);
      neg = (sx < 0) != (sy < 0);
      lat = (mq >= 256) ? 1 : N + 1;
      if (mq > (neg ? 128 : 127)) begin
        o = 1'b1; q = '1; r = '0;
      end else begin
        o = 1'b0; q = N'(sx / sy); r = N'(sx % sy);
      end
    end
`else
    int ix, iy;
    ix = int'(x);
    iy = int'(y);
    if (iy == 0) begin
      o = 1'b1; q = '1; r = '0; lat = 1;
    end else if (ix / iy > 255) begin
      o = 1'b1; q = '1; r = '0; lat = 1;
    end else begin
      o = 1'b0; q = N'(ix / iy); r = N'(ix % iy); lat = N + 1;
    end
`endif
  endtask

  task automatic op(input logic [2*N-1:0] x, input logic [N-1:0] y, input bit hold);
    logic [N-1:0] eq, er;
    logic eo;
    int lat, edges, bc;
    model(x, y, eq, er, eo, lat);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("held_q", quotient, pq);
    chk("held_r", remainder, pr);
    chk("held_ovf", ovf, po);
    st = 1'b1; a = x; b = y;
    edges = 0; bc = 0;
    do begin
      @(negedge clk);
      edges++;
      bc += int'(busy);
      if (!done) begin
        a = 16'($urandom);
        b = 8'($urandom);
        if (!hold) st = 1'($urandom);
      end else if (!hold) st = 1'b0;
    end while (!done && edges < 40);
    chk("latency", edges, lat);
    chk("busy_cycles", bc, lat);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("ovf", ovf, eo);
    pq = eq; pr = er; po = eo;
  endtask

  initial begin
    logic [2*N-1:0] x;
    logic [N-1:0] y;
    #2;
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    op(16'd100, 8'd7, 0);
    op(16'h00FF, 8'h01, 0);
    op(16'h1234, 8'h9A, 0);
    op(16'h5555, 8'h00, 0);
    op(16'hFF00, 8'hFF, 0);
    op(16'hFEFF, 8'hFF, 0);
    op(16'h0000, 8'h01, 0);
`ifdef COUNT_DIV_SIGNED_EN
    op(-16'sd100, 8'sd7, 0);
    op(16'h8000, 8'hFF, 0);
    op(-16'sd1024, 8'sd8, 0);
    op(16'sd1016, -8'sd8, 0);
    op(16'sd1024, -8'sd8, 0);
`endif
    for (int i = 0; i < 24; i++) begin
      x = 16'($urandom);
      y = 8'($urandom);
      if (i % 2 == 0) begin
        y = 8'($urandom_range(1, 255));
        x[15:8] = 8'($urandom_range(0, int'(y) - 1));
      end
      op(x, y, 0);
    end
    for (int i = 0; i < 6; i++) begin
      y = 8'($urandom_range(1, 255));
      x = 16'($urandom);
      if (i != 3) x[15:8] = 8'($urandom_range(0, int'(y) - 1));
      op(x, y, 1);
    end
    st = 1'b0;
    @(negedge clk) st = 1'b1; a = 16'd1000; b = 8'd9;
    @(negedge clk) st = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    rst_n = 1'b1;
    pq = '0; pr = '0; po = 1'b0;
    op(16'd1000, 8'd9, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
